// File: rtl/geofence_feeder.sv
// -----------------------------------------------------------------------------
// geofence_feeder
//
// Host-side transmitter for the geofence engine. It collects one frame from an
// upstream loader (a test point followed by NUM_VERT fence vertices), replays
// the frame to the engine one X/Y pair per cycle with the test point first,
// then waits a bounded time for the engine's valid/is_inside answer. Each
// frame ends with a one-cycle result pulse, and running statistics are kept
// in saturating counters.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : asynchronous, active-low reset
//   load_valid     : upstream word valid
//   load_ready     : feeder accepts an upstream word this cycle
//   load_x/load_y  : upstream coordinate pair (unsigned, CW bits each)
//   geo_x/geo_y    : coordinate pair driven to the engine
//   geo_start      : high alongside the test point (first word of a frame)
//   geo_valid      : engine result strobe (only honoured while waiting)
//   geo_is_inside  : engine result bit
//   result_valid   : one-cycle pulse per completed frame
//   result_inside  : engine answer, 0 on timeout; held until the next result
//   result_timeout : frame ended by timeout; held until the next result
//   frame_cnt      : completed frames (saturating)
//   inside_cnt     : frames answered inside (saturating)
//   timeout_cnt    : frames that timed out (saturating)
// -----------------------------------------------------------------------------
module geofence_feeder #(
  parameter int CW       = 10,
  parameter int NUM_VERT = 6,
  parameter int TIMEOUT  = 64,
  parameter int CNTW     = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [CW-1:0]   load_x,
  input  logic [CW-1:0]   load_y,
  output logic [CW-1:0]   geo_x,
  output logic [CW-1:0]   geo_y,
  output logic            geo_start,
  input  logic            geo_valid,
  input  logic            geo_is_inside,
  output logic            result_valid,
  output logic            result_inside,
  output logic            result_timeout,
  output logic [CNTW-1:0] frame_cnt,
  output logic [CNTW-1:0] inside_cnt,
  output logic [CNTW-1:0] timeout_cnt
);

  localparam int NWORDS = NUM_VERT + 1;
  localparam int IW     = $clog2(NWORDS);
  localparam int WW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_VERT);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SEND   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  state_e               state_q;
  logic [IW-1:0]        idx_q;
  logic [WW-1:0]        wait_q;
  logic [2*CW-1:0]      frame_q [NWORDS];   // {x, y} per word
  logic                 load_ready_q;
  logic [CW-1:0]        geo_x_q;
  logic [CW-1:0]        geo_y_q;
  logic                 geo_start_q;
  logic                 result_valid_q;
  logic                 result_inside_q;
  logic                 result_timeout_q;
  logic [CNTW-1:0]      frame_cnt_q;
  logic [CNTW-1:0]      inside_cnt_q;
  logic [CNTW-1:0]      timeout_cnt_q;

  // Statistics stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // NOTE: every register here, including the frame buffer, is in the async
  // reset because a reset mid-frame must leave no stale words or outputs.
  // NOTE: sequential state is written only with non-blocking assignments so
  // every read in this block sees the value from before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_LOAD;
      idx_q            <= '0;
      wait_q           <= '0;
      for (int i = 0; i < NWORDS; i++) frame_q[i] <= '0;
      load_ready_q     <= 1'b0;
      geo_x_q          <= '0;
      geo_y_q          <= '0;
      geo_start_q      <= 1'b0;
      result_valid_q   <= 1'b0;
      result_inside_q  <= 1'b0;
      result_timeout_q <= 1'b0;
      frame_cnt_q      <= '0;
      inside_cnt_q     <= '0;
      timeout_cnt_q    <= '0;
    end else begin
      // Pulse-style outputs default low; only the cases below raise them.
      result_valid_q <= 1'b0;
      geo_start_q    <= 1'b0;

      case (state_q)
        ST_LOAD: begin
          // load_ready is registered, so it rises on the first clock after
          // reset and words are only taken while it is already high.
          load_ready_q <= 1'b1;
          if (load_valid && load_ready_q) begin
            frame_q[idx_q] <= {load_x, load_y};
            if (idx_q == LAST_IDX) begin
              idx_q        <= '0;
              load_ready_q <= 1'b0;
              state_q      <= ST_SEND;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end

        ST_SEND: begin
          geo_x_q     <= frame_q[idx_q][2*CW-1:CW];
          geo_y_q     <= frame_q[idx_q][CW-1:0];
          geo_start_q <= (idx_q == '0);
          if (idx_q == LAST_IDX) begin
            // geo_x/geo_y keep the last vertex while waiting.
            idx_q   <= '0;
            wait_q  <= '0;
            state_q <= ST_WAIT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        ST_WAIT: begin
          // A valid answer on the limit cycle beats the timeout.
          if (geo_valid) begin
            result_valid_q   <= 1'b1;
            result_inside_q  <= geo_is_inside;
            result_timeout_q <= 1'b0;
            frame_cnt_q      <= sat_inc(frame_cnt_q);
            if (geo_is_inside) inside_cnt_q <= sat_inc(inside_cnt_q);
            state_q          <= ST_REPORT;
          end else if (wait_q == WAIT_LIMIT) begin
            result_valid_q   <= 1'b1;
            result_inside_q  <= 1'b0;
            result_timeout_q <= 1'b1;
            frame_cnt_q      <= sat_inc(frame_cnt_q);
            timeout_cnt_q    <= sat_inc(timeout_cnt_q);
            state_q          <= ST_REPORT;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end

        ST_REPORT: begin
          // The result pulse and counter updates are visible for exactly
          // this one cycle; loading resumes on the next.
          idx_q        <= '0;
          load_ready_q <= 1'b1;
          state_q      <= ST_LOAD;
        end

        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign load_ready     = load_ready_q;
  assign geo_x          = geo_x_q;
  assign geo_y          = geo_y_q;
  assign geo_start      = geo_start_q;
  assign result_valid   = result_valid_q;
  assign result_inside  = result_inside_q;
  assign result_timeout = result_timeout_q;
  assign frame_cnt      = frame_cnt_q;
  assign inside_cnt     = inside_cnt_q;
  assign timeout_cnt    = timeout_cnt_q;

endmodule

// File: doc/geofence_feeder.md
Name: geofence_feeder

Overview:
- Host-side transmitter for the geofence engine. Buffers one frame from an upstream loader: one test point plus NUM_VERT fence vertices.
- Replays the frame to the engine on its X/Y bus, one coordinate pair per cycle, test point first.
- Waits for the engine's valid/is_inside answer, with a timeout.
- Reports a per-frame result and keeps running frame, inside-hit and timeout counts.

Parameters:
- CW, 10, coordinate width per axis; matches the engine's X/Y width.
- NUM_VERT, 6, fence vertices per frame; frame length is NUM_VERT+1 words.
- TIMEOUT, 64, cycles allowed in WAIT before the frame is declared timed out; must be ≥2.
- CNTW, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  upstream word valid.
- load_ready  out  1  feeder accepts a word this cycle.
- load_x  in  CW  upstream X coordinate.
- load_y  in  CW  upstream Y coordinate.
- geo_x  out  CW  X coordinate driven to the engine.
- geo_y  out  CW  Y coordinate driven to the engine.
- geo_start  out  1  high on the test-point cycle of SEND (first word of a frame).
- geo_valid  in  1  engine result strobe.
- geo_is_inside  in  1  engine result bit.
- result_valid  out  1  one-cycle pulse per completed frame.
- result_inside  out  1  engine answer; 0 on timeout.
- result_timeout  out  1  frame ended by timeout.
- frame_cnt  out  CNTW  completed frames.
- inside_cnt  out  CNTW  frames answered inside.
- timeout_cnt  out  CNTW  timed-out frames.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to LOAD; buffer and index are cleared.
  - All outputs are 0, including the counters and geo_x/geo_y.
  - Reset asserted mid-frame abandons the frame with no result pulse.
- States: LOAD, SEND, WAIT, REPORT.
- LOAD:
  - load_ready=1.
  - Each cycle with load_valid=1 writes {load_x,load_y} to buf[idx] and increments idx.
  - Word 0 is the test point; words 1..NUM_VERT are vertices in order.
  - When the NUM_VERT-th vertex is accepted (idx==NUM_VERT), the state goes to SEND next cycle and idx clears.
  - load_valid=0 holds idx; there is no timeout in LOAD.
- SEND:
  - load_ready=0.
  - For NUM_VERT+1 consecutive cycles, geo_x/geo_y are registered from buf[idx], with idx 0..NUM_VERT.
  - geo_start=1 only when idx==0.
  - After idx==NUM_VERT is driven, the state goes to WAIT. geo_x/geo_y hold the last vertex and are not forced to 0.
- WAIT:
  - The wait counter starts at 0 and increments every cycle.
  - geo_valid=1: latch geo_is_inside and go to REPORT with timeout=0.
  - Wait counter reaches TIMEOUT-1 with no geo_valid: go to REPORT with timeout=1 and inside=0.
  - geo_valid on the same cycle as the timeout limit: the valid wins and it is not a timeout.
  - geo_valid seen in LOAD or SEND is ignored and does not affect counters.
- REPORT:
  - One cycle. result_valid=1; result_inside and result_timeout are driven from the latched values.
  - frame_cnt increments.
  - inside_cnt increments if inside; timeout_cnt increments if timeout.
  - Next state is LOAD with idx=0.
- result_inside and result_timeout hold their values until the next REPORT. result_valid is 0 outside REPORT.
- Counters saturate at all-ones and never wrap.
- Latency: the last load handshake precedes the first geo word by 1 cycle. Minimum frame period is (NUM_VERT+1) load + (NUM_VERT+1) send + ≥1 wait + 1 report cycles.
- Coordinates are treated as unsigned CW-bit values and passed through unmodified.

Test Plan:
- Reset, then load 7 words back-to-back: test (5,5), vertices (0,0),(10,0),(15,5),(10,10),(0,10),(-) → (2,8) used as 6th vertex.
  - Required: geo_start=1 with geo=(5,5) exactly 1 cycle after the last load, then the 6 vertices in order.
  - Engine model answers inside=1 after 3 cycles → result_valid pulse, result_inside=1, frame_cnt=1, inside_cnt=1.
- Upstream with load_valid gaps (1 of every 3 cycles):
  - Required: idx holds across gaps and the frame is sent intact.
  - load_ready=0 throughout SEND, WAIT and REPORT.
- Engine silent, TIMEOUT=64:
  - Required: result_valid exactly 64 cycles after entering WAIT, result_timeout=1, result_inside=0, timeout_cnt=1.
- geo_valid pulsed during SEND, then a real answer inside=0 in WAIT:
  - Required: the early pulse is ignored, result_inside=0 and inside_cnt is unchanged.
- geo_valid coincident with the timeout-limit cycle:
  - Required: result_timeout=0, the answer is latched, timeout_cnt is unchanged.
- Reset asserted on the 4th SEND cycle:
  - Required: outputs and counters are 0 immediately (asynchronous), no result_valid, load_ready=1 after release.
- Counter saturation: with CNTW=4, run 17 frames → frame_cnt stays 15.
